// File: rtl/dadda_mac_accum_pkg.sv
// Shared constants and types for the Dadda multiplier accumulator and the multiplier integration.
package dadda_mac_accum_pkg;

  localparam int unsigned MulLat  = 5;
  localparam int unsigned ProdW   = 16;
  localparam int unsigned AccWDef = 24;
  localparam int unsigned CntWDef = 8;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_tag_t;

  typedef struct packed {
    logic [AccWDef-1:0] data;
    logic               ovf;
    logic [CntWDef-1:0] beats;
  } result_t;

endpackage

// File: rtl/dadda_mac_accum_if.sv
// Operand-side tag handshake plus result valid/ready channel of the accumulator.
interface dadda_mac_accum_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
);
  import dadda_mac_accum_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [ProdW-1:0] prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_first, in_last, prod, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_first, in_last, prod, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_beats
  );

endinterface

// File: rtl/dadda_result_fifo.sv
// Small synchronous FIFO holding completed frame results; head is shown combinationally.
module dadda_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot this same edge, so a full FIFO can still take a push.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dadda_mac_accum.sv
// Accumulates delayed multiplier products into per-frame sums, buffered and credit-flow-controlled.
module dadda_mac_accum
  import dadda_mac_accum_pkg::*;
#(
  parameter int unsigned MUL_LAT    = MulLat,
  parameter int unsigned ACC_W      = AccWDef,
  parameter int unsigned CNT_W      = CntWDef,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  dadda_mac_accum_if.slave  bus
);

  localparam int unsigned CrW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ResW = ACC_W + 1 + CNT_W;

  beat_tag_t        tags_q [MUL_LAT];
  beat_tag_t        tail;
  logic [CrW-1:0]   credits_q, credits_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [ACC_W:0]   sum;
  logic             accept, push, pop, fifo_full, fifo_empty;
  logic [ResW-1:0]  fifo_head;

  assign bus.in_ready = (credits_q != '0);
  assign accept       = bus.in_valid & bus.in_ready;
  assign tail         = tags_q[MUL_LAT-1];
  assign push         = tail.valid & tail.last;
  assign pop          = bus.out_valid & bus.out_ready;
  assign sum          = {1'b0, acc_q} + (ACC_W + 1)'(bus.prod);

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    beats_d = beats_q;
    if (tail.valid) begin
      if (tail.first) begin
        acc_d   = ACC_W'(bus.prod);
        ovf_d   = 1'b0;
        beats_d = CNT_W'(1);
      end else begin
        acc_d   = sum[ACC_W-1:0];
        ovf_d   = ovf_q | sum[ACC_W];
        beats_d = beats_q + CNT_W'(1);
      end
    end
  end

  // One credit per FIFO slot, reserved when a frame's last beat enters the pipeline.
  always_comb begin
    credits_d = credits_q;
    unique case ({accept & bus.in_last, pop})
      2'b10:   credits_d = credits_q - CrW'(1);
      2'b01:   credits_d = credits_q + CrW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) tags_q[i] <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      beats_q   <= '0;
      credits_q <= CrW'(FIFO_DEPTH);
    end else begin
      tags_q[0] <= '{valid: accept, first: bus.in_first, last: bus.in_last};
      for (int unsigned i = 1; i < MUL_LAT; i++) tags_q[i] <= tags_q[i-1];
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      beats_q   <= beats_d;
      credits_q <= credits_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && fifo_full && !pop));
  end

  dadda_result_fifo #(
    .Width (ResW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({acc_d, ovf_d, beats_d}),
    .pop_i   (bus.out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (fifo_head)
  );

  assign bus.out_valid = ~fifo_empty;
  assign {bus.out_data, bus.out_ovf, bus.out_beats} = fifo_head;

endmodule
